// File: rtl/axis_frame_pkg.sv
// Shared types and helpers for the frame joiner / tag-strip pair.
package axis_frame_pkg;

    typedef enum logic {
        HEADER   = 1'b0,
        TRANSFER = 1'b1
    } state_t;

    // last + user travel alongside the data word through the skid stage
    localparam int SIDEBAND_W = 2;

    // Number of data words needed to carry the tag, never less than one
    function automatic int tag_word_width(input int tag_w, input int data_w);
        int n;
        n = (tag_w + data_w - 1) / data_w;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/axis_frame_tag_strip_skid.sv
// Two-entry registered output stage (output reg + skid reg).
// Upstream ready is registered: it is computed one cycle ahead from the
// next occupancy of the skid entry, so it never depends combinationally
// on the downstream ready.
module axis_skid_reg
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_user,
    input  logic                  i_valid,
    output logic                  o_ready_early,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_user,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int W = DATA_WIDTH + SIDEBAND_W;

    logic [W-1:0] r_out;
    logic [W-1:0] r_tmp;
    logic         r_out_vld;
    logic         r_tmp_vld;
    logic         r_rdy;

    logic [W-1:0] w_in;
    logic         w_acc;
    logic         w_load;
    logic         w_tmp_nxt;

    assign w_in   = {i_last, i_user, i_data};
    assign w_acc  = i_valid && r_rdy;
    // output slot is free to take a new word this cycle
    assign w_load = !r_out_vld || i_ready;
    // skid entry only fills when a word arrives while the output is stalled
    assign w_tmp_nxt = w_load ? 1'b0 : (r_tmp_vld || w_acc);

    // Output/skid register update; skid drains into output before new input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_tmp     <= '0;
            r_out_vld <= 1'b0;
            r_tmp_vld <= 1'b0;
            r_rdy     <= 1'b0;
        end else begin
            r_rdy     <= !w_tmp_nxt;
            r_tmp_vld <= w_tmp_nxt;
            if (w_load) begin
                if (r_tmp_vld) begin
                    r_out     <= r_tmp;
                    r_out_vld <= 1'b1;
                end else begin
                    r_out_vld <= w_acc;
                    if (w_acc) r_out <= w_in;
                end
            end else if (w_acc) begin
                r_tmp <= w_in;
            end
        end
    end

    assign o_ready_early = r_rdy;
    assign o_valid       = r_out_vld;
    assign o_last        = r_out[W-1];
    assign o_user        = r_out[W-2];
    assign o_data        = r_out[DATA_WIDTH-1:0];

endmodule

// File: rtl/axis_frame_tag_strip.sv
// Strips the little-endian tag header from a joined AXI4-Stream frame,
// presents the tag on a valid/ready sideband and forwards the payload
// through a skid output stage. Frames ending inside the header are dropped.
module axis_frame_tag_strip
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int TAG_WIDTH     = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [TAG_WIDTH-1:0]     m_tag,
    output logic                     m_tag_valid,
    input  logic                     m_tag_ready,
    output logic                     busy,
    output logic                     bad_frame,
    output logic [ERR_CNT_WIDTH-1:0] bad_frame_count
);

    localparam int TW    = tag_word_width(TAG_WIDTH, DATA_WIDTH);
    localparam int PTR_W = (TW > 1) ? $clog2(TW) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TW - 1);

    state_t                     r_state;
    logic [PTR_W-1:0]           r_ptr;
    logic [TW*DATA_WIDTH-1:0]   r_tag_acc;
    logic [TAG_WIDTH-1:0]       r_tag;
    logic                       r_tag_vld;
    logic                       r_bad;
    logic                       r_rdy_en;
    logic [ERR_CNT_WIDTH-1:0]   r_bad_cnt;

    logic [TW*DATA_WIDTH-1:0]   w_tag_full;
    logic                       w_last_hdr;
    logic                       w_hdr_rdy;
    logic                       w_skid_rdy;
    logic                       w_s_rdy;
    logic                       w_s_hs;
    logic                       w_hdr_hs;
    logic                       w_drop;
    logic                       w_tag_done;
    logic                       w_pay_vld;

    assign w_last_hdr = (r_ptr == LAST_PTR);
    // only the final header word waits for the tag slot to free up
    assign w_hdr_rdy  = w_last_hdr ? (!r_tag_vld || m_tag_ready) : 1'b1;
    assign w_s_rdy    = r_rdy_en && ((r_state == HEADER) ? w_hdr_rdy : w_skid_rdy);
    assign w_s_hs     = s_axis_tvalid && w_s_rdy;
    assign w_hdr_hs   = w_s_hs && (r_state == HEADER);
    assign w_drop     = w_hdr_hs && s_axis_tlast;
    assign w_tag_done = w_hdr_hs && w_last_hdr && !s_axis_tlast;
    assign w_pay_vld  = s_axis_tvalid && r_rdy_en && (r_state == TRANSFER);

    // Merge the incoming header word into the accumulator at the current slot
    always_comb begin
        w_tag_full = r_tag_acc;
        for (int k = 0; k < TW; k++) begin
            if (r_ptr == PTR_W'(k)) w_tag_full[k*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
        end
    end

    // Header/transfer FSM with registered tag sideband and drop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= HEADER;
            r_ptr     <= '0;
            r_tag_acc <= '0;
            r_tag     <= '0;
            r_tag_vld <= 1'b0;
            r_bad     <= 1'b0;
            r_rdy_en  <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            r_bad    <= w_drop;
            if (r_tag_vld && m_tag_ready) r_tag_vld <= 1'b0;
            // a new tag landing in the handshake cycle keeps valid asserted
            if (w_tag_done) begin
                r_tag     <= w_tag_full[TAG_WIDTH-1:0];
                r_tag_vld <= 1'b1;
            end
            if (r_state == HEADER) begin
                if (w_hdr_hs) begin
                    r_tag_acc <= w_tag_full;
                    r_ptr     <= (s_axis_tlast || w_last_hdr) ? '0 : r_ptr + 1'b1;
                    if (w_tag_done) r_state <= TRANSFER;
                end
            end else begin
                if (w_s_hs && s_axis_tlast) r_state <= HEADER;
            end
        end
    end

    // Saturating count of dropped frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad_cnt <= '0;
        end else if (w_drop && (r_bad_cnt != '1)) begin
            r_bad_cnt <= r_bad_cnt + 1'b1;
        end
    end

    axis_skid_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_data        (s_axis_tdata),
        .i_last        (s_axis_tlast),
        .i_user        (s_axis_tuser),
        .i_valid       (w_pay_vld),
        .o_ready_early (w_skid_rdy),
        .o_data        (m_axis_tdata),
        .o_last        (m_axis_tlast),
        .o_user        (m_axis_tuser),
        .o_valid       (m_axis_tvalid),
        .i_ready       (m_axis_tready)
    );

    assign s_axis_tready   = w_s_rdy;
    assign m_tag           = r_tag;
    assign m_tag_valid     = r_tag_vld;
    assign busy            = (r_state == TRANSFER) || (r_ptr != '0);
    assign bad_frame       = r_bad;
    assign bad_frame_count = r_bad_cnt;

endmodule

// File: tb/tb_axis_frame_tag_strip.sv
// Bench for axis_frame_tag_strip: scoreboard queues for payload and tag,
// a frame table with randomised backpressure, and hand sequences for
// latency, skid stall, tag stall, drop and async reset corners.
module tb_axis_frame_tag_strip;

    localparam int DW = 8;
    localparam int TGW = 16;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic           s_axis_tlast = 1'b0;
    logic           s_axis_tuser = 1'b0;
    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic           m_axis_tlast;
    logic           m_axis_tuser;
    logic [TGW-1:0] m_tag;
    logic           m_tag_valid;
    logic           m_tag_ready = 1'b1;
    logic           busy;
    logic           bad_frame;
    logic [CW-1:0]  bad_frame_count;

    always #5 clk = ~clk;

    axis_frame_tag_strip #(
        .DATA_WIDTH    (DW),
        .TAG_WIDTH     (TGW),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .m_tag           (m_tag),
        .m_tag_valid     (m_tag_valid),
        .m_tag_ready     (m_tag_ready),
        .busy            (busy),
        .bad_frame       (bad_frame),
        .bad_frame_count (bad_frame_count)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0]  pay_q[$];   // {last, user, data}
    logic [15:0] tag_q[$];
    int bad_seen = 0;
    int exp_bad = 0;

    // ready drivers: 0 = fixed value, 1 = pattern 1,0,0,1,0,1, 2 = random
    int   mr_mode = 0;
    logic mr_fix = 1'b1;
    int   tr_mode = 0;
    logic tr_fix = 1'b1;
    logic [5:0] pat = 6'b101001;

    typedef struct {
        logic [7:0]  h0;
        logic [7:0]  h1;
        int          len;
        logic [31:0] pay;
        logic        user;
        logic        bad;
        logic [15:0] exp_tag;
    } vec_t;
    vec_t vec[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int pi;
        pi = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0: m_axis_tready = mr_fix;
                1: begin m_axis_tready = pat[pi]; pi = (pi + 1) % 6; end
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            m_tag_ready = (tr_mode != 0) ? 1'($urandom_range(0, 1)) : tr_fix;
        end
    end

    // monitor: handshakes and hold-stability, sampled mid-cycle
    initial begin
        logic       p_stall, t_stall;
        logic [9:0] p_prev, w;
        logic [15:0] t_prev;
        p_stall = 1'b0; t_stall = 1'b0; p_prev = '0; t_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_stall = 1'b0;
                t_stall = 1'b0;
            end else begin
                w = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
                if (p_stall) chk("pay_hold", {21'd0, m_axis_tvalid, w}, {21'd0, 1'b1, p_prev});
                if (m_axis_tvalid && m_axis_tready) begin
                    if (pay_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pay_extra: got %0h expected no word", w);
                    end else begin
                        chk("pay_data", {22'd0, w}, {22'd0, pay_q.pop_front()});
                    end
                end
                p_stall = m_axis_tvalid && !m_axis_tready;
                p_prev  = w;
                if (t_stall) chk("tag_hold", {15'd0, m_tag_valid, m_tag}, {15'd0, 1'b1, t_prev});
                if (m_tag_valid && m_tag_ready) begin
                    if (tag_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tag_extra: got %0h expected no tag", m_tag);
                    end else begin
                        chk("tag_data", {16'd0, m_tag}, {16'd0, tag_q.pop_front()});
                    end
                end
                t_stall = m_tag_valid && !m_tag_ready;
                t_prev  = m_tag;
                if (bad_frame) bad_seen++;
            end
        end
    end

    task automatic send_word(input logic [7:0] d, input logic l, input logic u);
        int n;
        n = 0;
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u; s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            checks++; errors++;
            $display("FAIL send_timeout: word %0h never accepted", d);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    endtask

    task automatic push_pay(input logic [7:0] d, input logic l, input logic u);
        pay_q.push_back({l, u, d});
    endtask

    task automatic send_rec(input vec_t r);
        logic l;
        if (r.bad) begin
            exp_bad++;
            send_word(r.h0, 1'b1, 1'b0);
        end else begin
            tag_q.push_back(r.exp_tag);
            for (int i = 0; i < r.len; i++) begin
                l = (i == r.len - 1);
                push_pay(r.pay[8*i +: 8], l, r.user && l);
            end
            send_word(r.h0, 1'b0, 1'b0);
            send_word(r.h1, 1'b0, 1'b0);
            for (int i = 0; i < r.len; i++) begin
                l = (i == r.len - 1);
                send_word(r.pay[8*i +: 8], l, r.user && l);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((pay_q.size() != 0 || tag_q.size() != 0 || m_axis_tvalid || m_tag_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain: pay_q %0d tag_q %0d left, expected 0", pay_q.size(), tag_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{h0: 8'h34, h1: 8'h12, len: 3, pay: 32'h00CCBBAA, user: 1'b0, bad: 1'b0, exp_tag: 16'h1234};
        vec[1] = '{h0: 8'hEF, h1: 8'hBE, len: 1, pay: 32'h0000005A, user: 1'b1, bad: 1'b0, exp_tag: 16'hBEEF};
        vec[2] = '{h0: 8'h00, h1: 8'h00, len: 0, pay: 32'h0,        user: 1'b0, bad: 1'b1, exp_tag: 16'h0000};
        vec[3] = '{h0: 8'hFF, h1: 8'hFF, len: 4, pay: 32'h04030201, user: 1'b0, bad: 1'b0, exp_tag: 16'hFFFF};
        vec[4] = '{h0: 8'h01, h1: 8'h80, len: 2, pay: 32'h0000A55A, user: 1'b1, bad: 1'b0, exp_tag: 16'h8001};

        // reset state
        #12;
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_tagvld", {31'd0, m_tag_valid}, 32'd0);
        chk("rst_tag", {16'd0, m_tag}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, bad_frame_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_tready", {31'd0, s_axis_tready}, 32'd1);

        // 1: nominal frame, tag and first-word latency
        tag_q.push_back(16'h1234);
        push_pay(8'hAA, 1'b0, 1'b0);
        push_pay(8'hBB, 1'b0, 1'b0);
        push_pay(8'hCC, 1'b1, 1'b0);
        send_word(8'h34, 1'b0, 1'b0);
        chk("t1_busy_hdr", {31'd0, busy}, 32'd1);
        send_word(8'h12, 1'b0, 1'b0);
        chk("t1_tagvld", {31'd0, m_tag_valid}, 32'd1);
        chk("t1_tag", {16'd0, m_tag}, 32'h1234);
        send_word(8'hAA, 1'b0, 1'b0);
        chk("t1_lat_vld", {31'd0, m_axis_tvalid}, 32'd1);
        chk("t1_lat_data", {24'd0, m_axis_tdata}, 32'hAA);
        chk("t1_tag_once", {31'd0, m_tag_valid}, 32'd0);
        send_word(8'hBB, 1'b0, 1'b0);
        send_word(8'hCC, 1'b1, 1'b0);
        wait_drain();

        // 2: backpressure; skid fills and upstream ready drops
        mr_fix = 1'b0;
        tag_q.push_back(16'h1234);
        push_pay(8'hAA, 1'b0, 1'b0);
        push_pay(8'hBB, 1'b0, 1'b0);
        push_pay(8'hCC, 1'b1, 1'b0);
        send_word(8'h34, 1'b0, 1'b0);
        send_word(8'h12, 1'b0, 1'b0);
        send_word(8'hAA, 1'b0, 1'b0);
        send_word(8'hBB, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_tready_drop", {31'd0, s_axis_tready}, 32'd0);
        chk("t2_out_stall", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, 8'hAA});
        @(posedge clk);
        #1;
        mr_mode = 1;
        send_word(8'hCC, 1'b1, 1'b0);
        wait_drain();
        mr_mode = 0;
        mr_fix = 1'b1;

        // 3: tag stall holds off only the final header word
        tr_fix = 1'b0;
        tag_q.push_back(16'h1234);
        push_pay(8'hAA, 1'b1, 1'b0);
        send_word(8'h34, 1'b0, 1'b0);
        send_word(8'h12, 1'b0, 1'b0);
        send_word(8'hAA, 1'b1, 1'b0);
        send_word(8'h78, 1'b0, 1'b0);
        s_axis_tdata = 8'h56; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_off", {31'd0, s_axis_tready}, 32'd0);
        end
        tr_fix = 1'b1;
        @(negedge clk);
        chk("t3_release", {31'd0, s_axis_tready}, 32'd1);
        chk("t3_old_tag", {15'd0, m_tag_valid, m_tag}, {15'd0, 1'b1, 16'h1234});
        tag_q.push_back(16'h5678);
        push_pay(8'hBB, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        chk("t3_new_tag", {15'd0, m_tag_valid, m_tag}, {15'd0, 1'b1, 16'h5678});
        send_word(8'hBB, 1'b1, 1'b0);
        wait_drain();

        // 4: tlast inside header drops the frame
        exp_bad++;
        send_word(8'h34, 1'b1, 1'b0);
        chk("t4_pulse", {31'd0, bad_frame}, 32'd1);
        chk("t4_count", {16'd0, bad_frame_count}, exp_bad);
        chk("t4_no_tag", {31'd0, m_tag_valid}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("t4_pulse_end", {31'd0, bad_frame}, 32'd0);
        send_rec(vec[0]);
        wait_drain();

        // 5: tuser on the last beat only
        tag_q.push_back(16'h1234);
        push_pay(8'hAA, 1'b0, 1'b0);
        push_pay(8'hBB, 1'b1, 1'b1);
        send_word(8'h34, 1'b0, 1'b0);
        send_word(8'h12, 1'b0, 1'b0);
        send_word(8'hAA, 1'b0, 1'b0);
        send_word(8'hBB, 1'b1, 1'b1);
        wait_drain();

        // frame table under random backpressure on both outputs
        mr_mode = 2;
        tr_mode = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) send_rec(vec[i]);
        end
        wait_drain();
        mr_mode = 0;
        tr_mode = 0;
        chk("tbl_count", {16'd0, bad_frame_count}, exp_bad);
        chk("tbl_pulses", bad_seen, exp_bad);
        @(posedge clk);
        #1;

        // 6: async reset after the second payload word
        tag_q.push_back(16'h1234);
        push_pay(8'hAA, 1'b0, 1'b0);
        push_pay(8'hBB, 1'b0, 1'b0);
        send_word(8'h34, 1'b0, 1'b0);
        send_word(8'h12, 1'b0, 1'b0);
        send_word(8'hAA, 1'b0, 1'b0);
        send_word(8'hBB, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("t6_mdata", {24'd0, m_axis_tdata}, 32'd0);
        chk("t6_tag", {15'd0, m_tag_valid, m_tag}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_cnt", {16'd0, bad_frame_count}, 32'd0);
        chk("t6_tready", {31'd0, s_axis_tready}, 32'd0);
        pay_q.delete();
        tag_q.delete();
        exp_bad = 0;
        bad_seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rel_tready", {31'd0, s_axis_tready}, 32'd1);
        tag_q.push_back(16'h5678);
        push_pay(8'h11, 1'b1, 1'b0);
        send_word(8'h78, 1'b0, 1'b0);
        chk("t6_hdr0_busy", {31'd0, busy}, 32'd1);
        send_word(8'h56, 1'b0, 1'b0);
        chk("t6_tag_new", {16'd0, m_tag}, 32'h5678);
        send_word(8'h11, 1'b1, 1'b0);
        wait_drain();
        chk("t6_no_bad", {16'd0, bad_frame_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_tag_strip.md
Name: axis_frame_tag_strip

Overview:
- Downstream stage of the frame joiner.
- Consumes a joined AXI4-Stream frame made of TAG_WORD_WIDTH header words carrying the tag, little-endian word order (word 0 = tag[DATA_WIDTH-1:0]), followed by the payload.
- Strips the header, presents the tag on a separate valid/ready sideband, and forwards the payload through a registered skid-buffered output.
- Malformed frames, where tlast arrives inside the header, are discarded and counted.

Parameters:
- DATA_WIDTH, 8, width of the data word on both the input and output stream.
- TAG_WIDTH, 16, width of the tag. TAG_WORD_WIDTH = ceil(TAG_WIDTH/DATA_WIDTH) is derived, minimum 1.
- ERR_CNT_WIDTH, 16, width of the saturating bad-frame counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of frame
- s_axis_tuser  in  1  input error flag, meaningful on tlast only
- m_axis_tdata  out  DATA_WIDTH  payload data
- m_axis_tvalid  out  1  payload valid
- m_axis_tready  in  1  payload ready
- m_axis_tlast  out  1  payload end of frame
- m_axis_tuser  out  1  payload error flag, copied from the input on tlast
- m_tag  out  TAG_WIDTH  extracted tag
- m_tag_valid  out  1  tag valid
- m_tag_ready  in  1  tag ready
- busy  out  1  high while in TRANSFER, or while a header is partially accepted
- bad_frame  out  1  one-cycle pulse when a malformed frame is dropped
- bad_frame_count  out  ERR_CNT_WIDTH  saturating count of dropped frames

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to HEADER with frame_ptr = 0.
  - All valid outputs, bad_frame, busy, bad_frame_count, m_tag and m_axis_tdata are 0.
  - s_axis_tready is 0 while in reset. It may rise on the first clock after release.
  - Reset mid-frame discards the partial header and any buffered payload words. The first word after reset is treated as header word 0.
- FSM HEADER:
  - s_axis_tready = 1 for words 0..TAG_WORD_WIDTH-2.
  - For the final header word, s_axis_tready = !m_tag_valid || m_tag_ready. A pending tag therefore only stalls the last header word.
  - Each accepted word is written to tag_acc[ptr*DATA_WIDTH +: DATA_WIDTH]; bits above TAG_WIDTH are discarded. ptr increments.
  - Final word accepted with tlast = 0:
    - m_tag <= assembled tag (the final word merged combinationally); m_tag_valid <= 1 next cycle.
    - ptr <= 0; go to TRANSFER.
  - Any header word accepted with tlast = 1:
    - Frame dropped; no tag is emitted.
    - bad_frame pulses for 1 cycle; bad_frame_count increments, saturating at all-ones.
    - ptr <= 0; stay in HEADER.
- FSM TRANSFER:
  - s_axis_tready = m_axis_tready_int_early from the skid output stage.
  - Each accepted word is forwarded with tdata/tlast/tuser unchanged.
  - On an accepted word with tlast = 1, go to HEADER next cycle.
- Tag sideband:
  - m_tag_valid clears on m_tag_valid && m_tag_ready.
  - If the final header word of the next frame is accepted in the same cycle as the tag handshake, m_tag_valid stays 1 and m_tag loads the new tag.
  - m_tag is stable while m_tag_valid && !m_tag_ready.
- Payload output:
  - Latency is 1 cycle from the s_axis handshake to m_axis_tvalid.
  - Full throughput (1 word/cycle) when m_axis_tready is held high.
  - m_axis_tdata/tlast/tuser are stable while m_axis_tvalid && !m_axis_tready.
  - No word is lost or duplicated under arbitrary backpressure (2-entry skid).
- busy = (state == TRANSFER) || (ptr != 0).
- Zero-length payload is not supported: a tlast on the final header word counts as malformed.

Decomposition:
- Package axis_frame_pkg:
  - state enum {HEADER, TRANSFER}
  - function tag_word_width(TAG_WIDTH, DATA_WIDTH), shared with the frame joiner
- One sub-module axis_skid_reg:
  - 2-entry output register with early-ready generation, parameterised on DATA_WIDTH plus 2 sideband bits (last, user).
  - Reusable by the joiner's output stage.

Test Plan:
All scenarios use DATA_WIDTH = 8, TAG_WIDTH = 16.
1. Nominal frame: input 0x34, 0x12, 0xAA, 0xBB, 0xCC (last), m_axis_tready = 1, m_tag_ready = 1 -> m_tag = 0x1234 with one valid cycle; payload AA, BB, CC with tlast on CC; first payload word valid exactly 1 cycle after its input handshake.
2. Backpressure: same frame with m_axis_tready toggled 1,0,0,1,0,1 -> payload order and values unchanged, output stable during stalls, s_axis_tready drops within 2 stalled cycles.
3. Tag stall: m_tag_ready = 0, two back-to-back frames with tags 0x1234 and 0x5678 -> second frame's word 0x56 held off (s_axis_tready = 0) until m_tag_ready rises. In that handshake cycle 0x56 is accepted and m_tag becomes 0x5678 next cycle with m_tag_valid continuously 1.
4. Malformed frame: input 0x34 (last) -> no tag, no payload, bad_frame pulses once, count = 1. The following good frame is parsed correctly, with header starting at ptr 0.
5. tuser passthrough: payload last word with s_axis_tuser = 1 -> m_axis_tuser = 1 on the m_axis_tlast beat only.
6. Async reset mid-payload: assert rst_n low after the 2nd payload word -> all outputs 0 immediately. After release, the next word 0x78 is taken as header word 0.
